// File: rtl/sound_evt_pkg.sv
// ---------------------------------------------------------------------------
// sound_evt_pkg
// Shared definitions for the sound event front end.
//   EDGE_*      : per-channel edge qualification modes (2 bits per channel)
//   arb_state_t : states of the event arbiter
// ---------------------------------------------------------------------------
package sound_evt_pkg;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

endpackage : sound_evt_pkg

// File: rtl/sound_debounce_edge.sv
// ---------------------------------------------------------------------------
// sound_debounce_edge
// One event channel: 2-flop synchroniser, debounce filter and qualified
// edge strobe.
//   clk      : system clock
//   nRst     : asynchronous active-low reset
//   event_i  : raw asynchronous event level
//   stable_o : debounced level
//   edge_o   : one-cycle strobe, high in the cycle the debounced level
//              takes its new value, when the direction matches MODE
// ---------------------------------------------------------------------------
module sound_debounce_edge
    import sound_evt_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter logic [1:0] MODE            = EDGE_RISE
) (
    input  logic clk,
    input  logic nRst,
    input  logic event_i,
    output logic stable_o,
    output logic edge_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             edge_q, edge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = event_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        edge_d   = 1'b0;
        if (sync2_q == stable_q) begin
            // Any return to the stable level restarts the qualification.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            // The strobe is registered alongside the new stable level, so it
            // is visible in the same cycle the level changes.
            case (MODE)
                EDGE_RISE: edge_d = sync2_q;
                EDGE_FALL: edge_d = ~sync2_q;
                EDGE_BOTH: edge_d = 1'b1;
                default:   edge_d = 1'b0;
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            edge_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            edge_q   <= edge_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign edge_o   = edge_q;

endmodule : sound_debounce_edge

// File: rtl/sound_event_arbiter.sv
// ---------------------------------------------------------------------------
// sound_event_arbiter
// N-channel event front end for the sound generator. Each channel is
// synchronised, debounced and edge-qualified; qualified edges are latched as
// pending and offered one at a time (channel 0 highest priority) over a
// valid/ready handshake. A re-trigger while still pending is flagged as lost.
//   clk          : system clock
//   nRst         : asynchronous active-low reset
//   event_i      : raw asynchronous event levels
//   edge_pulse_o : one-cycle qualified edge strobe per channel
//   pending_o    : events latched and not yet accepted
//   ev_valid_o   : event offered to the sound generator
//   ev_id_o      : channel index of the offered event
//   ev_ready_i   : sound generator accepts the offered event
//   overflow_o   : sticky per-channel lost-event flag
//   ovf_clear_i  : synchronous clear of all overflow flags
// ---------------------------------------------------------------------------
module sound_event_arbiter
    import sound_evt_pkg::*;
#(
    parameter int                  NUM_CH          = 3,
    parameter int                  DEBOUNCE_CYCLES = 4,
    parameter logic [2*NUM_CH-1:0] EDGE_MODE       = {NUM_CH{2'b00}},
    localparam int                 ID_W            = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [NUM_CH-1:0] event_i,
    output logic [NUM_CH-1:0] edge_pulse_o,
    output logic [NUM_CH-1:0] pending_o,
    output logic              ev_valid_o,
    output logic [ID_W-1:0]   ev_id_o,
    input  logic              ev_ready_i,
    output logic [NUM_CH-1:0] overflow_o,
    input  logic              ovf_clear_i
);

    logic [NUM_CH-1:0] edge_pulse;
    // Debounced levels are kept for observation only; arbitration works on
    // the edge strobes.
    logic [NUM_CH-1:0] stable_lvl_unused;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            sound_debounce_edge #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .MODE            (EDGE_MODE[2*gi +: 2])
            ) u_deb (
                .clk      (clk),
                .nRst     (nRst),
                .event_i  (event_i[gi]),
                .stable_o (stable_lvl_unused[gi]),
                .edge_o   (edge_pulse[gi])
            );
        end
    endgenerate

    arb_state_t        state_q, state_d;
    logic              ev_valid_q, ev_valid_d;
    logic [ID_W-1:0]   ev_id_q, ev_id_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overflow_q, overflow_d;
    logic [NUM_CH-1:0] accept;
    logic [ID_W-1:0]   first_id;

    always_comb begin
        accept = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            accept[c] = (state_q == OFFER) && ev_ready_i && (ev_id_q == ID_W'(c));
        end

        // A strobe coinciding with acceptance re-arms pending as a new event
        // and is not a loss.
        pending_d  = (pending_q & ~accept) | edge_pulse;
        overflow_d = (ovf_clear_i ? '0 : overflow_q)
                   | (edge_pulse & pending_q & ~accept);

        // Lowest-index pending channel wins.
        first_id = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pending_q[c]) first_id = ID_W'(c);
        end

        state_d    = state_q;
        ev_valid_d = ev_valid_q;
        ev_id_d    = ev_id_q;
        case (state_q)
            IDLE: begin
                ev_valid_d = 1'b0;
                if (|pending_q) begin
                    ev_id_d    = first_id;
                    ev_valid_d = 1'b1;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                // Offer is held unchanged until taken, whatever else arrives.
                if (ev_ready_i) begin
                    ev_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                ev_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            ev_valid_q <= ev_valid_d;
            ev_id_q    <= ev_id_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign edge_pulse_o = edge_pulse;
    assign pending_o    = pending_q;
    assign ev_valid_o   = ev_valid_q;
    assign ev_id_o      = ev_id_q;
    assign overflow_o   = overflow_q;

endmodule : sound_event_arbiter

// File: tb/tb_sound_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sound_event_arbiter
// Directed bench for sound_event_arbiter: NUM_CH=3, DEBOUNCE_CYCLES=4,
// ch0 rise, ch1 both, ch2 fall. A vector table covers the basic event path
// and a short glitch; hand-written sequences cover priority, stalls,
// overflow and reset during an offer.
// ---------------------------------------------------------------------------
module tb_sound_event_arbiter;

    localparam int NUM_CH = 3;
    localparam int DEB    = 4;

    logic              clk = 1'b0;
    logic              nRst;
    logic [NUM_CH-1:0] event_i;
    logic [NUM_CH-1:0] edge_pulse_o;
    logic [NUM_CH-1:0] pending_o;
    logic              ev_valid_o;
    logic [1:0]        ev_id_o;
    logic              ev_ready_i;
    logic [NUM_CH-1:0] overflow_o;
    logic              ovf_clear_i;

    sound_event_arbiter #(
        .NUM_CH          (NUM_CH),
        .DEBOUNCE_CYCLES (DEB),
        .EDGE_MODE       (6'b01_10_00)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .event_i      (event_i),
        .edge_pulse_o (edge_pulse_o),
        .pending_o    (pending_o),
        .ev_valid_o   (ev_valid_o),
        .ev_id_o      (ev_id_o),
        .ev_ready_i   (ev_ready_i),
        .overflow_o   (overflow_o),
        .ovf_clear_i  (ovf_clear_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ev;
        logic       rdy;
        logic       clr;
        logic [2:0] exp_edge;
        logic [2:0] exp_pend;
        logic       exp_val;
        logic [1:0] exp_id;
        logic [2:0] exp_ovf;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   pulse_cnt[NUM_CH];

    function automatic void add(logic [2:0] ev, logic rdy, logic clr,
                                logic [2:0] e, logic [2:0] p, logic v,
                                logic [1:0] id, logic [2:0] o);
        vec_t t;
        t.ev = ev; t.rdy = rdy; t.clr = clr;
        t.exp_edge = e; t.exp_pend = p; t.exp_val = v; t.exp_id = id; t.exp_ovf = o;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) pulse_cnt[c] += int'(edge_pulse_o[c]);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NUM_CH; c++) pulse_cnt[c] = 0;
    endtask

    initial begin
        nRst        = 1'b0;
        event_i     = '0;
        ev_ready_i  = 1'b0;
        ovf_clear_i = 1'b0;
        clear_counts();

        steps(2);
        chk("reset_edge",  32'(edge_pulse_o), 32'h0);
        chk("reset_pend",  32'(pending_o),    32'h0);
        chk("reset_valid", 32'(ev_valid_o),   32'h0);
        chk("reset_ovf",   32'(overflow_o),   32'h0);
        nRst = 1'b1;

        // ---- vector table: one row per clock edge ----
        // ch0 rises: strobe after the 6th edge, pending next, offer next,
        // ready while idle ignored, accept on the following edge.
        for (int i = 0; i < 5; i++) add(3'b001, 0, 0, 3'b000, 3'b000, 0, 2'd0, 3'b000);
        add(3'b001, 0, 0, 3'b001, 3'b000, 0, 2'd0, 3'b000);
        add(3'b001, 1, 0, 3'b000, 3'b001, 0, 2'd0, 3'b000);
        add(3'b001, 1, 0, 3'b000, 3'b001, 1, 2'd0, 3'b000);
        add(3'b001, 1, 0, 3'b000, 3'b000, 0, 2'd0, 3'b000);
        add(3'b001, 0, 0, 3'b000, 3'b000, 0, 2'd0, 3'b000);
        // 3-cycle glitch on ch1 must be rejected.
        for (int i = 0; i < 3; i++) add(3'b011, 0, 0, 3'b000, 3'b000, 0, 2'd0, 3'b000);
        for (int i = 0; i < 7; i++) add(3'b001, 0, 0, 3'b000, 3'b000, 0, 2'd0, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            event_i     = vecs[i].ev;
            ev_ready_i  = vecs[i].rdy;
            ovf_clear_i = vecs[i].clr;
            step();
            $display("vec %0d ev=%b rdy=%b edge=%b pend=%b val=%b id=%0d ovf=%b",
                     i, vecs[i].ev, vecs[i].rdy, edge_pulse_o, pending_o,
                     ev_valid_o, ev_id_o, overflow_o);
            chk($sformatf("vec%0d_edge", i), 32'(edge_pulse_o), 32'(vecs[i].exp_edge));
            chk($sformatf("vec%0d_pend", i), 32'(pending_o),    32'(vecs[i].exp_pend));
            chk($sformatf("vec%0d_val", i),  32'(ev_valid_o),   32'(vecs[i].exp_val));
            if (vecs[i].exp_val)
                chk($sformatf("vec%0d_id", i), 32'(ev_id_o), 32'(vecs[i].exp_id));
            chk($sformatf("vec%0d_ovf", i),  32'(overflow_o),   32'(vecs[i].exp_ovf));
        end

        // ---- edge modes: ch1 both, ch2 fall ----
        ev_ready_i = 1'b1;
        clear_counts();
        event_i = 3'b111;
        steps(DEB + 1);
        chk("mode_rise_early", 32'(edge_pulse_o), 32'h0);
        step();
        chk("mode_rise_edge", 32'(edge_pulse_o), 32'b010);
        steps(10);
        event_i = 3'b001;
        steps(DEB + 2);
        chk("mode_fall_edge", 32'(edge_pulse_o), 32'b110);
        steps(12);
        chk("mode_ch1_pulses", 32'(pulse_cnt[1]), 32'd2);
        chk("mode_ch2_pulses", 32'(pulse_cnt[2]), 32'd1);
        chk("mode_ch0_pulses", 32'(pulse_cnt[0]), 32'd0);
        chk("mode_drained_pend", 32'(pending_o), 32'h0);
        chk("mode_drained_val",  32'(ev_valid_o), 32'h0);
        $display("modes ch1_pulses=%0d ch2_pulses=%0d", pulse_cnt[1], pulse_cnt[2]);

        // ---- priority and stall: ch0 and ch2 strobe together ----
        ev_ready_i = 1'b0;
        clear_counts();
        event_i = 3'b100;        // ch0 falls (rise mode), ch2 rises (fall mode)
        steps(10);
        chk("prio_setup_pulses", 32'(pulse_cnt[0] + pulse_cnt[2]), 32'd0);
        event_i = 3'b001;        // ch0 rises, ch2 falls: both qualify
        steps(DEB + 2);
        chk("prio_edge", 32'(edge_pulse_o), 32'b101);
        step();
        chk("prio_pend", 32'(pending_o), 32'b101);
        step();
        chk("prio_offer_val", 32'(ev_valid_o), 32'h1);
        chk("prio_offer_id",  32'(ev_id_o),    32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stall%0d_val", k), 32'(ev_valid_o), 32'h1);
            chk($sformatf("stall%0d_id", k),  32'(ev_id_o),    32'h0);
        end
        ev_ready_i = 1'b1;
        step();
        chk("prio_acc0_pend", 32'(pending_o),  32'b100);
        chk("prio_acc0_val",  32'(ev_valid_o), 32'h0);
        step();
        chk("prio_offer2_val", 32'(ev_valid_o), 32'h1);
        chk("prio_offer2_id",  32'(ev_id_o),    32'h2);
        step();
        chk("prio_acc2_pend", 32'(pending_o),  32'h0);
        chk("prio_acc2_val",  32'(ev_valid_o), 32'h0);
        ev_ready_i = 1'b0;
        $display("priority sequence done");

        // ---- overflow: ch0 retriggers while pending ----
        event_i = 3'b000;
        steps(8);
        event_i = 3'b001;
        steps(DEB + 4);
        chk("ovf_first_val", 32'(ev_valid_o), 32'h1);
        chk("ovf_first_ovf", 32'(overflow_o), 32'h0);
        event_i = 3'b000;
        steps(8);
        event_i = 3'b001;
        steps(DEB + 2);
        chk("ovf_second_edge", 32'(edge_pulse_o), 32'b001);
        ovf_clear_i = 1'b1;      // clear coincides with the set
        step();
        chk("ovf_set_wins", 32'(overflow_o), 32'b001);
        chk("ovf_pend",     32'(pending_o),  32'b001);
        step();
        chk("ovf_cleared", 32'(overflow_o), 32'h0);
        ovf_clear_i = 1'b0;
        // strobe coincident with acceptance
        event_i = 3'b000;
        steps(8);
        event_i = 3'b001;
        steps(DEB + 2);
        chk("coinc_edge", 32'(edge_pulse_o), 32'b001);
        chk("coinc_val",  32'(ev_valid_o),   32'h1);
        ev_ready_i = 1'b1;
        step();
        chk("coinc_pend", 32'(pending_o),  32'b001);
        chk("coinc_ovf",  32'(overflow_o), 32'h0);
        chk("coinc_val0", 32'(ev_valid_o), 32'h0);
        ev_ready_i = 1'b0;
        step();
        chk("coinc_reoffer_val", 32'(ev_valid_o), 32'h1);
        chk("coinc_reoffer_id",  32'(ev_id_o),    32'h0);
        ev_ready_i = 1'b1;
        step();
        chk("coinc_done_pend", 32'(pending_o), 32'h0);
        ev_ready_i = 1'b0;
        $display("overflow sequence done");

        // ---- reset during an offer ----
        event_i = 3'b011;
        steps(8);
        chk("rst_pre_val", 32'(ev_valid_o), 32'h1);
        chk("rst_pre_id",  32'(ev_id_o),    32'h1);
        event_i = 3'b001;
        steps(8);
        chk("rst_pre_ovf", 32'(overflow_o), 32'b010);
        #2;
        nRst = 1'b0;
        #1;
        chk("rst_async_val",  32'(ev_valid_o), 32'h0);
        chk("rst_async_pend", 32'(pending_o),  32'h0);
        chk("rst_async_ovf",  32'(overflow_o), 32'h0);
        step();
        nRst = 1'b1;
        steps(DEB + 1);
        chk("rst_rel_early", 32'(edge_pulse_o), 32'h0);
        step();
        chk("rst_rel_edge", 32'(edge_pulse_o), 32'b001);
        $display("reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sound_event_arbiter
